// File: rtl/eth_vlg_sp_frame_buf.sv
// eth_vlg_sp_frame_buf
// Frame-aware byte FIFO controller in front of one single-port RAM with a
// registered read port (q valid one cycle after the read is issued).
// Bytes are stored as {last, byte}. A frame becomes readable only once its
// last byte has been accepted, which commits it.
// The write side and the read prefetch share the single RAM port. Writes
// win, except when the output side would otherwise starve. Reads use the
// cycles the writer leaves idle.
// Optional feature: define ETH_VLG_FBUF_DISCARD_EN to drop frames whose last
// byte arrives with wr_err=1. When it is not defined, wr_err has no effect.
module eth_vlg_sp_frame_buf #(
  parameter int AW = 11,
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_v,
  input  logic [DW-2:0] wr_d,
  input  logic          wr_last,
  input  logic          wr_err,
  output logic          wr_rdy,
  output logic          rd_v,
  output logic [DW-2:0] rd_d,
  output logic          rd_last,
  input  logic          rd_rdy,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_d,
  output logic          ram_w,
  input  logic [DW-1:0] ram_q,
  output logic          ovf
);

  localparam logic [AW-1:0] PTR_MAX = {AW{1'b1}};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t        state_r;
  logic          ovf_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] cmt_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] iss_ptr_r;
  logic          inflight_r;
  logic          head_v_r;
  logic [DW-1:0] head_d_r;
  logic          skid_v_r;
  logic [DW-1:0] skid_d_r;

  logic [AW-1:0] used_s;
  logic [AW-1:0] pend_s;
  logic          full_s;
  logic          readable_s;
  logic [1:0]    occ_s;
  logic          starve_s;
  logic          wr_rdy_s;
  logic          wr_acc_s;
  logic          wr_mem_s;
  logic          rd_iss_s;
  logic          ovf_hit_s;
  logic          bad_s;
  logic          commit_s;
  logic          rollback_s;
  logic          pop_s;

  assign used_s     = wr_ptr_r - rd_ptr_r;
  assign pend_s     = wr_ptr_r - cmt_ptr_r;
  assign full_s     = (used_s == PTR_MAX);
  // The issue pointer stops at the commit pointer, so the frame still being
  // written is never prefetched.
  assign readable_s = (iss_ptr_r != cmt_ptr_r);
  assign occ_s      = {1'b0, head_v_r} + {1'b0, skid_v_r} + {1'b0, inflight_r};
  // The head being empty implies the skid entry is empty as well.
  assign starve_s   = ~head_v_r & readable_s & ~inflight_r;

`ifdef ETH_VLG_FBUF_DISCARD_EN
  assign bad_s = wr_err;
`else
  // wr_err is deliberately without effect in this build.
  assign bad_s = 1'b0 & wr_err;
`endif

  // Write-side ready: held off while full or when the reader must be fed first;
  // always ready while discarding.
  always_comb begin
    wr_rdy_s = 1'b0;
    case (state_r)
      ST_IDLE:    wr_rdy_s = ~full_s & ~starve_s;
      ST_DISCARD: wr_rdy_s = 1'b1;
      default:    wr_rdy_s = 1'b0;
    endcase
  end

  assign wr_acc_s   = wr_v & wr_rdy_s;
  assign wr_mem_s   = wr_acc_s & (state_r == ST_IDLE);
  assign commit_s   = wr_mem_s & wr_last & ~bad_s;
  assign rollback_s = wr_mem_s & wr_last & bad_s;
  // The frame fills the whole RAM on its own, so it can never complete.
  assign ovf_hit_s  = (state_r == ST_IDLE) & wr_v & full_s & (pend_s == PTR_MAX);
  assign rd_iss_s   = readable_s & (occ_s < 2'd2) & ~wr_mem_s & (state_r != ST_INIT);
  assign pop_s      = head_v_r & rd_rdy;

  assign wr_rdy  = wr_rdy_s;
  assign ram_w   = wr_mem_s;
  assign ram_a   = wr_mem_s ? wr_ptr_r : iss_ptr_r;
  assign ram_d   = wr_mem_s ? {wr_last, wr_d} : {DW{1'b0}};
  assign rd_v    = head_v_r;
  assign rd_d    = head_d_r[DW-2:0];
  assign rd_last = head_d_r[DW-1];
  assign ovf     = ovf_r;

  // Frame state machine: leaves reset through INIT, enters DISCARD on
  // overflow, and raises a one-cycle ovf pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_INIT;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          state_r <= ST_IDLE;
          ovf_r   <= 1'b0;
        end
        ST_IDLE: begin
          if (ovf_hit_s) begin
            state_r <= ST_DISCARD;
            ovf_r   <= 1'b1;
          end else begin
            ovf_r   <= 1'b0;
          end
        end
        ST_DISCARD: begin
          ovf_r <= 1'b0;
          if (wr_acc_s && wr_last) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          ovf_r   <= 1'b0;
        end
      endcase
    end
  end

  // Write and commit pointers: advance on stored bytes, commit on a good
  // last byte, and roll back to the last commit on overflow or a bad frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r  <= {AW{1'b0}};
      cmt_ptr_r <= {AW{1'b0}};
    end else begin
      if (ovf_hit_s || rollback_s) begin
        wr_ptr_r <= cmt_ptr_r;
      end else if (wr_mem_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (commit_s) begin
        cmt_ptr_r <= wr_ptr_r + PTR_ONE;
      end
    end
  end

  // Read pointers: the issue pointer walks the prefetch, and the read
  // pointer frees RAM slots only when the consumer pops a byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iss_ptr_r  <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= rd_iss_s;
      if (rd_iss_s) begin
        iss_ptr_r <= iss_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Two-entry output buffer: the head drives rd_*, and the skid entry
  // catches a returning read while the head is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_v_r <= 1'b0;
      head_d_r <= {DW{1'b0}};
      skid_v_r <= 1'b0;
      skid_d_r <= {DW{1'b0}};
    end else begin
      if (pop_s || !head_v_r) begin
        if (skid_v_r) begin
          head_v_r <= 1'b1;
          head_d_r <= skid_d_r;
          skid_v_r <= inflight_r;
          if (inflight_r) begin
            skid_d_r <= ram_q;
          end
        end else if (inflight_r) begin
          head_v_r <= 1'b1;
          head_d_r <= ram_q;
        end else begin
          head_v_r <= 1'b0;
        end
      end else if (inflight_r) begin
        skid_v_r <= 1'b1;
        skid_d_r <= ram_q;
      end
    end
  end

endmodule

// File: tb/tb_eth_vlg_sp_frame_buf.sv
// Bench for eth_vlg_sp_frame_buf: a large instance (AW=11, unit 0) and a
// small one (AW=4, unit 1), each with its own RAM model. Expected read bytes
// are queued when frames are sent, and a negedge monitor pops the queue and
// compares on every read transfer.
`timescale 1ns/1ps
module tb_eth_vlg_sp_frame_buf;
  localparam int AWB    = 11;
  localparam int AWS    = 4;
  localparam int BUDGET = 400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [1:0]      wr_v, wr_last, wr_err, wr_rdy, rd_v, rd_last, rd_rdy, ram_w, ovf;
  logic [1:0][7:0] wr_d, rd_d;
  logic [1:0][8:0] ram_d, ram_q;
  logic [AWB-1:0]  ram_a0;
  logic [AWS-1:0]  ram_a1;
  logic [8:0]      mem0 [0:(1<<AWB)-1];
  logic [8:0]      mem1 [0:(1<<AWS)-1];

  int checks = 0, failures = 0, cyc = 0, commit_cyc = 0;
  int acc_cnt[2]    = '{0, 0};
  int ovf_cnt[2]    = '{0, 0};
  int ovf_at[2]     = '{0, 0};
  int cur_idx[2]    = '{0, 0};
  int rdv_seen[2]   = '{0, 0};
  int first_rise[2] = '{-1, -1};
  int rd_mode[2]    = '{0, 0};
  logic [8:0] exp0[$];
  logic [8:0] exp1[$];
  logic [1:0] prev_v = 2'b00, hold_p = 2'b00;
  logic [1:0][8:0] hold_d;
  logic [10:0] a_tmp;

  eth_vlg_sp_frame_buf #(.AW(AWB), .DW(9)) u_big (
    .clk(clk), .rst(rst), .wr_v(wr_v[0]), .wr_d(wr_d[0]), .wr_last(wr_last[0]),
    .wr_err(wr_err[0]), .wr_rdy(wr_rdy[0]), .rd_v(rd_v[0]), .rd_d(rd_d[0]),
    .rd_last(rd_last[0]), .rd_rdy(rd_rdy[0]), .ram_a(ram_a0), .ram_d(ram_d[0]),
    .ram_w(ram_w[0]), .ram_q(ram_q[0]), .ovf(ovf[0]));

  eth_vlg_sp_frame_buf #(.AW(AWS), .DW(9)) u_small (
    .clk(clk), .rst(rst), .wr_v(wr_v[1]), .wr_d(wr_d[1]), .wr_last(wr_last[1]),
    .wr_err(wr_err[1]), .wr_rdy(wr_rdy[1]), .rd_v(rd_v[1]), .rd_d(rd_d[1]),
    .rd_last(rd_last[1]), .rd_rdy(rd_rdy[1]), .ram_a(ram_a1), .ram_d(ram_d[1]),
    .ram_w(ram_w[1]), .ram_q(ram_q[1]), .ovf(ovf[1]));

  // Single-port RAM models with a registered read port.
  always @(posedge clk) begin
    if (ram_w[0]) mem0[ram_a0] <= ram_d[0];
    ram_q[0] <= mem0[ram_a0];
    if (ram_w[1]) mem1[ram_a1] <= ram_d[1];
    ram_q[1] <= mem1[ram_a1];
  end

  // Cycle counter used to measure read latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Consumer ready per unit: 0 = stalled, 1 = always ready, 2 = toggling.
  initial begin
    rd_rdy = 2'b00;
    forever begin
      @(posedge clk); #1;
      for (int u = 0; u < 2; u++) begin
        case (rd_mode[u])
          1:       rd_rdy[u] = 1'b1;
          2:       rd_rdy[u] = ~rd_rdy[u];
          default: rd_rdy[u] = 1'b0;
        endcase
      end
    end
  end

  // Monitor: scoreboard compare on transfers, hold stability, and ovf/rd_v bookkeeping.
  initial begin
    forever begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        if (!rst) begin
          hold_p[u] = 1'b0;
          prev_v[u] = 1'b0;
        end else begin
          if (hold_p[u]) begin
            chk("hold_rd_v", {31'd0, rd_v[u]}, 32'd1);
            chk("hold_rd_data", {23'd0, rd_last[u], rd_d[u]}, {23'd0, hold_d[u]});
          end
          if (rd_v[u]) rdv_seen[u]++;
          if (rd_v[u] && !prev_v[u] && first_rise[u] < 0) first_rise[u] = cyc;
          if (ovf[u]) begin
            ovf_cnt[u]++;
            ovf_at[u] = cur_idx[u];
          end
          if (rd_v[u] && rd_rdy[u]) begin
            logic [8:0] e;
            int n;
            n = (u == 0) ? exp0.size() : exp1.size();
            if (n == 0) begin
              chk("sb_unexpected_rd", {23'd0, rd_last[u], rd_d[u]}, 32'h0000_0fff);
            end else begin
              if (u == 0) e = exp0.pop_front();
              else        e = exp1.pop_front();
              chk("sb_rd_data", {23'd0, rd_last[u], rd_d[u]}, {23'd0, e});
            end
          end
          hold_p[u] = rd_v[u] & ~rd_rdy[u];
          hold_d[u] = {rd_last[u], rd_d[u]};
          prev_v[u] = rd_v[u];
        end
      end
    end
  end

  task automatic push_exp(input int u, input logic [8:0] v);
    if (u == 0) exp0.push_back(v);
    else        exp1.push_back(v);
  endtask

  // Present one byte (called at posedge+1) and hold it until it is accepted.
  task automatic wr_byte(input int u, input logic [7:0] d, input logic lst,
                         input logic err, output logic [10:0] a);
    int w;
    logic ok;
    wr_v[u] = 1'b1; wr_d[u] = d; wr_last[u] = lst; wr_err[u] = err;
    w = 0; ok = 1'b0; a = 11'd0;
    while (!ok && w < BUDGET) begin
      @(negedge clk);
      if (wr_rdy[u]) begin
        ok = 1'b1;
        a = (u == 0) ? ram_a0 : {7'd0, ram_a1};
      end else begin
        w++;
      end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL wr_accept_timeout: unit %0d byte 0x%0h never accepted, required within %0d cycles", u, d, BUDGET);
    end
    @(posedge clk); #1;
    if (ok) acc_cnt[u]++;
    wr_v[u] = 1'b0; wr_last[u] = 1'b0; wr_err[u] = 1'b0;
  endtask

  task automatic send_frame(input int u, input int n, input logic [7:0] base,
                            input logic err, input logic push);
    logic [10:0] a;
    for (int i = 0; i < n; i++) begin
      logic [7:0] d;
      logic l;
      d = base + i[7:0];
      l = (i == n - 1);
      cur_idx[u] = i + 1;
      if (push) push_exp(u, {l, d});
      wr_byte(u, d, l, err, a);
    end
  endtask

  task automatic drain(input int u);
    int w, n;
    w = 0;
    n = (u == 0) ? exp0.size() : exp1.size();
    while (n != 0 && w < 1000) begin
      @(negedge clk);
      w++;
      n = (u == 0) ? exp0.size() : exp1.size();
    end
    chk("drain_left", n, 32'd0);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input int u);
    logic [10:0] a;
    a = (u == 0) ? ram_a0 : {7'd0, ram_a1};
    chk("rst_wr_rdy",  {31'd0, wr_rdy[u]}, 32'd0);
    chk("rst_rd_v",    {31'd0, rd_v[u]}, 32'd0);
    chk("rst_rd_d",    {24'd0, rd_d[u]}, 32'd0);
    chk("rst_rd_last", {31'd0, rd_last[u]}, 32'd0);
    chk("rst_ram_w",   {31'd0, ram_w[u]}, 32'd0);
    chk("rst_ram_a",   {21'd0, a}, 32'd0);
    chk("rst_ram_d",   {23'd0, ram_d[u]}, 32'd0);
    chk("rst_ovf",     {31'd0, ovf[u]}, 32'd0);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    wr_v = 2'b00; wr_d = '0; wr_last = 2'b00; wr_err = 2'b00;
    repeat (3) @(negedge clk);
    check_zero(0);
    check_zero(1);
    rst = 1'b1;
    @(posedge clk); #1;

    // 64-byte frame, always-ready reader: bytes in order, rd_v two cycles after commit.
    rd_mode[0] = 1;
    first_rise[0] = -1;
    send_frame(0, 64, 8'h00, 1'b0, 1'b1);
    commit_cyc = cyc;
    drain(0);
    chk("commit_to_rd_v_latency", first_rise[0] - commit_cyc, 32'd2);

    // Frames of 10, 1 and 20 bytes back-to-back, reader toggling.
    rd_mode[0] = 2;
    send_frame(0, 10, 8'h80, 1'b0, 1'b1);
    send_frame(0, 1,  8'hA5, 1'b0, 1'b1);
    send_frame(0, 20, 8'hC0, 1'b0, 1'b1);
    drain(0);
    chk("ovf_none_big", ovf_cnt[0], 32'd0);

    // AW=4 overflow: a 20-byte frame with the reader idle is dropped at byte 16.
    rd_mode[1] = 0;
    rdv_seen[1] = 0;
    send_frame(1, 20, 8'h10, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    chk("ovf_count", ovf_cnt[1], 32'd1);
    chk("ovf_at_byte", ovf_at[1], 32'd16);
    chk("ovf_no_rd_v", rdv_seen[1], 32'd0);
    @(posedge clk); #1;
    rd_mode[1] = 1;
    send_frame(1, 5, 8'h60, 1'b0, 1'b1);
    drain(1);

    // AW=4 backpressure: two 10-byte frames, reader stalled until the buffer is full.
    rd_mode[1] = 0;
    acc_cnt[1] = 0;
    fork
      begin
        send_frame(1, 10, 8'h20, 1'b0, 1'b1);
        send_frame(1, 10, 8'h40, 1'b0, 1'b1);
      end
      begin
        int w;
        w = 0;
        while (acc_cnt[1] < 15 && w < BUDGET) begin
          @(negedge clk);
          w++;
        end
        repeat (8) @(negedge clk);
        chk("bp_accepted_at_full", acc_cnt[1], 32'd15);
        chk("bp_wr_rdy_low", {31'd0, wr_rdy[1]}, 32'd0);
        rd_mode[1] = 1;
      end
    join
    drain(1);
    chk("ovf_count_after_bp", ovf_cnt[1], 32'd1);

    // Frame ending with wr_err=1, followed by a good frame.
    rd_mode[0] = 1;
    rdv_seen[0] = 0;
`ifdef ETH_VLG_FBUF_DISCARD_EN
    send_frame(0, 12, 8'h30, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    chk("err_frame_no_rd_v", rdv_seen[0], 32'd0);
    @(posedge clk); #1;
`else
    send_frame(0, 12, 8'h30, 1'b1, 1'b1);
`endif
    send_frame(0, 4, 8'hE0, 1'b0, 1'b1);
    drain(0);
    chk("ovf_none_err", ovf_cnt[0], 32'd0);

    // Async reset mid-frame while a read is pending.
    rd_mode[0] = 0;
    send_frame(0, 8, 8'h70, 1'b0, 1'b1);
    repeat (6) @(negedge clk);
    chk("pre_rst_rd_v", {31'd0, rd_v[0]}, 32'd1);
    @(posedge clk); #1;
    wr_byte(0, 8'h99, 1'b0, 1'b0, a_tmp);
    wr_byte(0, 8'h9A, 1'b0, 1'b0, a_tmp);
    #2 rst = 1'b0;
    #1;
    check_zero(0);
    check_zero(1);
    exp0.delete();
    exp1.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rd_mode[0] = 1;
    push_exp(0, {1'b0, 8'h50});
    wr_byte(0, 8'h50, 1'b0, 1'b0, a_tmp);
    chk("post_rst_first_addr", {21'd0, a_tmp}, 32'd0);
    send_frame(0, 5, 8'h51, 1'b0, 1'b1);
    drain(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
